// File: rtl/ahb_rr_arbiter_if.sv
// Bus-control signals shared by the masters, the slaves and the round-robin arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding bus.
interface ahb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 2
);
  localparam int MW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES  > 2) ? $clog2(NUM_SLAVES)  : 1;

  logic [NUM_MASTERS-1:0] busreq_i;
  logic                   read_write_i;
  logic [SW-1:0]          slave_id_i;
  logic                   ready_i;
  logic [1:0]             response_i;
  logic [NUM_MASTERS-1:0] split_done_i;

  logic [NUM_MASTERS-1:0] grant_o;
  logic [MW-1:0]          mst_sel_o;
  logic [NUM_SLAVES-1:0]  sel_o;
  logic                   aout_o;
  logic                   dout_o;
  logic [NUM_MASTERS-1:0] split_mask_o;
  logic                   xfer_done_o;
  logic                   error_o;

  modport master (
    input  busreq_i, read_write_i, slave_id_i, ready_i, response_i, split_done_i,
    output grant_o, mst_sel_o, sel_o, aout_o, dout_o, split_mask_o, xfer_done_o, error_o
  );

  modport slave (
    output busreq_i, read_write_i, slave_id_i, ready_i, response_i, split_done_i,
    input  grant_o, mst_sel_o, sel_o, aout_o, dout_o, split_mask_o, xfer_done_o, error_o
  );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Round-robin bus arbiter for N masters and S slaves with SPLIT masking,
// bounded RETRY and bounded wait-state timeout.
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 2,
  parameter int RETRY_LIMIT = 7,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ahb_rr_arbiter_if.master bus
);
  localparam int MW  = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW  = (NUM_SLAVES  > 2) ? $clog2(NUM_SLAVES)  : 1;
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int RCW = $clog2(RETRY_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_XFER  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } resp_e;

  state_e                 state_q, state_d;
  logic [MW-1:0]          owner_q, owner_d;
  logic [MW-1:0]          last_owner_q, last_owner_d;
  logic                   rw_q, rw_d;
  logic [SW-1:0]          slave_q, slave_d;
  logic [RCW-1:0]         retry_q, retry_d;
  logic [WCW-1:0]         wait_q, wait_d;
  logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d, split_set;
  logic                   xfer_done_q, xfer_done_d;
  logic                   error_q, error_d;
  logic                   exit_xfer;
  logic [MW:0]            pick;

  // Returns {found, index}: first set bit of elig searching upward from last+1 with wrap.
  // Scanning from the farthest candidate down lets the nearest one overwrite the result.
  function automatic logic [MW:0] rr_pick(input logic [NUM_MASTERS-1:0] elig,
                                          input logic [MW-1:0]          last);
    logic [MW:0] res;
    int          idx;
    res = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_MASTERS;
      if (elig[idx]) res = {1'b1, MW'(idx)};
    end
    return res;
  endfunction

  assign pick = rr_pick(bus.busreq_i & ~split_mask_q, last_owner_q);

  // NOTE: every signal gets its default before the case so no path leaves one unassigned;
  // a missed default here would infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rw_d         = rw_q;
    slave_d      = slave_q;
    retry_d      = retry_q;
    wait_d       = wait_q;
    split_set    = '0;
    xfer_done_d  = 1'b0;
    error_d      = 1'b0;
    exit_xfer    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick[MW]) begin
          owner_d = pick[MW-1:0];
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        rw_d    = bus.read_write_i;
        slave_d = bus.slave_id_i;
        if (int'(bus.slave_id_i) >= NUM_SLAVES) begin
          error_d      = 1'b1;
          last_owner_d = owner_q;
          state_d      = S_IDLE;
        end else begin
          retry_d = '0;
          wait_d  = '0;
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        if (!bus.ready_i) begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WCW'(TIMEOUT - 1)) begin
            error_d   = 1'b1;
            exit_xfer = 1'b1;
          end
        end else begin
          case (resp_e'(bus.response_i))
            RESP_OKAY: begin
              xfer_done_d = 1'b1;
              exit_xfer   = 1'b1;
            end
            RESP_ERROR: begin
              error_d   = 1'b1;
              exit_xfer = 1'b1;
            end
            RESP_RETRY: begin
              retry_d = retry_q + 1'b1;
              wait_d  = '0;
              if (retry_q == RCW'(RETRY_LIMIT - 1)) begin
                error_d   = 1'b1;
                exit_xfer = 1'b1;
              end
            end
            RESP_SPLIT: begin
              split_set[owner_q] = 1'b1;
              exit_xfer          = 1'b1;
            end
            default: ;
          endcase
        end
        if (exit_xfer) begin
          state_d      = S_IDLE;
          last_owner_d = owner_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // A slave release and a new split for the same master on one edge: the split wins.
  assign split_mask_d = (split_mask_q & ~bus.split_done_i) | split_set;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= MW'(NUM_MASTERS - 1);
      rw_q         <= 1'b0;
      slave_q      <= '0;
      retry_q      <= '0;
      wait_q       <= '0;
      split_mask_q <= '0;
      xfer_done_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rw_q         <= rw_d;
      slave_q      <= slave_d;
      retry_q      <= retry_d;
      wait_q       <= wait_d;
      split_mask_q <= split_mask_d;
      xfer_done_q  <= xfer_done_d;
      error_q      <= error_d;
    end
  end

  // Moore decode: controls depend only on registered state, so reset clears them at once.
  always_comb begin
    bus.grant_o   = '0;
    bus.mst_sel_o = '0;
    bus.sel_o     = '0;
    bus.aout_o    = 1'b0;
    bus.dout_o    = 1'b0;
    if (state_q != S_IDLE) begin
      bus.grant_o[owner_q] = 1'b1;
      bus.mst_sel_o        = owner_q;
    end
    if (state_q == S_XFER) begin
      bus.sel_o[slave_q] = 1'b1;
      bus.aout_o         = 1'b1;
      bus.dout_o         = rw_q;
    end
  end

  assign bus.split_mask_o = split_mask_q;
  assign bus.xfer_done_o  = xfer_done_q;
  assign bus.error_o      = error_q;

endmodule
